// File: rtl/alu_cmd_if.sv
// -----------------------------------------------------------------------------
// alu_cmd_if
//
// Command / response stream bundle between a caller (control or sequencing
// logic) and alu_cmd_driver.
//
//   Command stream (caller -> driver)
//     cmd_valid   command present
//     cmd_ready   driver can accept a command
//     cmd_opcode  ALU opcode (000 ADD .. 111 SHR)
//     cmd_a       operand A
//     cmd_b       operand B
//     cmd_tag     caller tag, echoed on the response
//
//   Response stream (driver -> caller)
//     rsp_valid   response present
//     rsp_ready   caller accepts the response
//     rsp_result  sampled ALU result
//     rsp_opcode  opcode of the completed command
//     rsp_tag     echoed tag
//
// Modports:
//   master - the caller side (drives commands, accepts responses)
//   slave  - the driver side (accepts commands, drives responses)
// -----------------------------------------------------------------------------
interface alu_cmd_if #(
    parameter int TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_opcode;
    logic [7:0]       cmd_a;
    logic [7:0]       cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_result;
    logic [2:0]       rsp_opcode;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_opcode, rsp_tag
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_opcode, rsp_tag
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// -----------------------------------------------------------------------------
// alu_cmd_driver
//
// Initiator side of the combinational ALU. Accepts one command at a time on a
// valid/ready stream, registers the opcode and operands onto the ALU inputs,
// waits SETTLE_CYCLES clock edges, samples the ALU result and returns it with
// the caller's tag on a valid/ready response stream. Turns the combinational
// ALU into a handshaked, clocked execution unit with one command in flight.
//
// Parameters:
//   SETTLE_CYCLES  edges from command accept to result sample, legal 1..15
//   TAG_W          width of the command/response tag
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   bus            alu_cmd_if.slave: command and response streams
//   alu_opcode     registered opcode to the ALU
//   alu_operand_a  registered operand A to the ALU
//   alu_operand_b  registered operand B to the ALU
//   alu_result     combinational result from the ALU
//   busy           high while a command is settling or awaiting handshake
//   op_count       completed response handshakes, wraps at 16 bits
//
// All outputs are registers; cmd_valid and rsp_ready only steer next state.
// -----------------------------------------------------------------------------
module alu_cmd_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int TAG_W         = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    alu_cmd_if.slave    bus,

    output logic [2:0]  alu_opcode,
    output logic [7:0]  alu_operand_a,
    output logic [7:0]  alu_operand_b,
    input  logic [7:0]  alu_result,

    output logic        busy,
    output logic [15:0] op_count
);

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    // The counter is preloaded with SETTLE_CYCLES-1 so that a zero count on
    // the current edge means "this is the sampling edge".
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]        state;
    logic [CNT_W-1:0]  settle_cnt;
    logic              cmd_ready_q;
    logic              busy_q;
    logic [15:0]       op_count_q;

    logic [2:0]        alu_opcode_p0;
    logic [DATA_W-1:0] alu_a_p0;
    logic [DATA_W-1:0] alu_b_p0;
    logic [TAG_W-1:0]  tag_p0;

    logic              rsp_vld_p1;
    logic [DATA_W-1:0] rsp_result_p1;
    logic [2:0]        rsp_opcode_p1;
    logic [TAG_W-1:0]  rsp_tag_p1;

    logic              cmd_fire;
    logic              rsp_fire;

    assign cmd_fire = bus.cmd_valid && cmd_ready_q;
    assign rsp_fire = rsp_vld_p1 && bus.rsp_ready;

    function automatic logic [15:0] count_inc(input logic [15:0] cnt);
        // Natural 16-bit wrap from 0xFFFF to 0x0000.
        count_inc = cnt + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            settle_cnt    <= '0;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            op_count_q    <= '0;
            alu_opcode_p0 <= '0;
            alu_a_p0      <= '0;
            alu_b_p0      <= '0;
            tag_p0        <= '0;
            rsp_vld_p1    <= 1'b0;
            rsp_result_p1 <= '0;
            rsp_opcode_p1 <= '0;
            rsp_tag_p1    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Stage p0: capture the command onto the ALU inputs.
                    if (cmd_fire) begin
                        alu_opcode_p0 <= bus.cmd_opcode;
                        alu_a_p0      <= bus.cmd_a;
                        alu_b_p0      <= bus.cmd_b;
                        tag_p0        <= bus.cmd_tag;
                        settle_cnt    <= SETTLE_LOAD;
                        cmd_ready_q   <= 1'b0;
                        busy_q        <= 1'b1;
                        state         <= ST_SETTLE;
                    end else begin
                        // First edge out of reset raises cmd_ready here.
                        cmd_ready_q   <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    // Stage p1: sample the settled ALU result.
                    if (settle_cnt != '0) begin
                        settle_cnt    <= settle_cnt - 1'b1;
                    end else begin
                        rsp_result_p1 <= alu_result;
                        rsp_opcode_p1 <= alu_opcode_p0;
                        rsp_tag_p1    <= tag_p0;
                        rsp_vld_p1    <= 1'b1;
                        state         <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // Response held until consumed; no limit on backpressure.
                    if (rsp_fire) begin
                        rsp_vld_p1  <= 1'b0;
                        busy_q      <= 1'b0;
                        op_count_q  <= count_inc(op_count_q);
                        cmd_ready_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a quiet IDLE.
                    state       <= ST_IDLE;
                    cmd_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                    rsp_vld_p1  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_vld_p1;
    assign bus.rsp_result = rsp_result_p1;
    assign bus.rsp_opcode = rsp_opcode_p1;
    assign bus.rsp_tag    = rsp_tag_p1;

    assign alu_opcode    = alu_opcode_p0;
    assign alu_operand_a = alu_a_p0;
    assign alu_operand_b = alu_b_p0;
    assign busy          = busy_q;
    assign op_count      = op_count_q;

    // Only one command may be in flight.
    a_ready_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(cmd_ready_q && busy_q));

    a_busy_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
        busy_q == (state != ST_IDLE));

    // A stalled response must not change underneath the consumer.
    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_vld_p1 && !bus.rsp_ready) |=>
            (rsp_vld_p1 && $stable(rsp_result_p1) && $stable(rsp_opcode_p1)
             && $stable(rsp_tag_p1)));

endmodule

// File: tb/tb_alu_cmd_driver.sv
module tb_alu_cmd_driver;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_cmd_if #(.TAG_W(TAG_W)) bus1 ();
    alu_cmd_if #(.TAG_W(TAG_W)) bus2 ();

    logic [2:0]  op1, op2;
    logic [7:0]  a1, b1, r1, a2, b2, r2;
    logic        busy1, busy2;
    logic [15:0] cnt1, cnt2;

    alu_cmd_driver #(.SETTLE_CYCLES(1), .TAG_W(TAG_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .alu_opcode(op1), .alu_operand_a(a1), .alu_operand_b(b1),
        .alu_result(r1), .busy(busy1), .op_count(cnt1)
    );

    alu_cmd_driver #(.SETTLE_CYCLES(3), .TAG_W(TAG_W)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .alu_opcode(op2), .alu_operand_a(a2), .alu_operand_b(b2),
        .alu_result(r2), .busy(busy2), .op_count(cnt2)
    );

    // Stand-in for the combinational ALU.
    function automatic logic [7:0] alu_model(input logic [2:0] op,
                                             input logic [7:0] a,
                                             input logic [7:0] b);
        case (op)
            3'd0:    alu_model = a + b;
            3'd1:    alu_model = a - b;
            3'd2:    alu_model = a & b;
            3'd3:    alu_model = a | b;
            3'd4:    alu_model = a ^ b;
            3'd5:    alu_model = ~a;
            3'd6:    alu_model = a << 1;
            default: alu_model = a >> 1;
        endcase
    endfunction

    always_comb r1 = alu_model(op1, a1, b1);
    always_comb r2 = alu_model(op2, a2, b2);

    int n_vec = 0;
    int n_bad = 0;

    task automatic apply_reset();
        bus1.cmd_valid = 1'b0; bus1.rsp_ready = 1'b0;
        bus2.cmd_valid = 1'b0; bus2.rsp_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        n_vec++; if (bus1.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %0d want 0", bus1.cmd_ready); end
        n_vec++; if (bus1.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %0d want 0", bus1.rsp_valid); end
        n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0d want 0", busy1); end
        n_vec++; if ({op1, a1, b1} !== 19'd0) begin n_bad++; $display("FAIL rst_alu_outs: got %0h want 0", {op1, a1, b1}); end
        n_vec++; if ({bus1.rsp_result, bus1.rsp_opcode, bus1.rsp_tag} !== 15'd0) begin n_bad++; $display("FAIL rst_rsp_fields: got %0h want 0", {bus1.rsp_result, bus1.rsp_opcode, bus1.rsp_tag}); end
        n_vec++; if (cnt1 !== 16'd0) begin n_bad++; $display("FAIL rst_op_count: got %0d want 0", cnt1); end
        rst_n = 1'b1;
        n_vec++; if (bus1.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_release_ready: got %0d want 0", bus1.cmd_ready); end
        @(posedge clk); #1;
        n_vec++; if (bus1.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_edge: got %0d want 1", bus1.cmd_ready); end
        n_vec++; if (bus2.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_edge_s3: got %0d want 1", bus2.cmd_ready); end
        n_vec++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL busy_after_edge: got %0d want 0", busy1); end
    endtask

    task automatic test_add();
        bus1.cmd_opcode = 3'd0; bus1.cmd_a = 8'd15; bus1.cmd_b = 8'd5; bus1.cmd_tag = 4'd3;
        bus1.cmd_valid = 1'b1; bus1.rsp_ready = 1'b1;
        @(posedge clk); #1;   // accept edge N
        bus1.cmd_valid = 1'b0;
        n_vec++; if (bus1.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL add_ready_cleared: got %0d want 0", bus1.cmd_ready); end
        n_vec++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL add_busy: got %0d want 1", busy1); end
        n_vec++; if ({op1, a1, b1} !== {3'd0, 8'd15, 8'd5}) begin n_bad++; $display("FAIL add_alu_drive: got %0h want %0h", {op1, a1, b1}, {3'd0, 8'd15, 8'd5}); end
        n_vec++; if (bus1.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_rsp_early: got %0d want 0", bus1.rsp_valid); end
        @(posedge clk); #1;   // edge N+1
        n_vec++; if (bus1.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL add_rsp_valid: got %0d want 1", bus1.rsp_valid); end
        n_vec++; if (bus1.rsp_result !== 8'd20) begin n_bad++; $display("FAIL add_result: got %0d want 20", bus1.rsp_result); end
        n_vec++; if (bus1.rsp_opcode !== 3'd0) begin n_bad++; $display("FAIL add_opcode: got %0d want 0", bus1.rsp_opcode); end
        n_vec++; if (bus1.rsp_tag !== 4'd3) begin n_bad++; $display("FAIL add_tag: got %0d want 3", bus1.rsp_tag); end
        @(posedge clk); #1;   // handshake edge
        n_vec++; if (bus1.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL add_rsp_clear: got %0d want 0", bus1.rsp_valid); end
        n_vec++; if (cnt1 !== 16'd1) begin n_bad++; $display("FAIL add_op_count: got %0d want 1", cnt1); end
        n_vec++; if (bus1.cmd_ready !== 1'b1 || busy1 !== 1'b0) begin n_bad++; $display("FAIL add_back_idle: got ready=%0d busy=%0d want ready=1 busy=0", bus1.cmd_ready, busy1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_res [6];
        logic acc, ok;
        exp_res = '{8'd20, 8'd10, 8'd5, 8'd15, 8'd10, 8'd240};
        apply_reset();
        bus1.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus1.cmd_opcode = 3'(i); bus1.cmd_a = 8'd15; bus1.cmd_b = 8'd5;
            bus1.cmd_tag = 4'(i + 8); bus1.cmd_valid = 1'b1;
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                acc = bus1.cmd_ready;
                @(posedge clk); #1;
                if (acc) begin ok = 1'b1; break; end
            end
            bus1.cmd_valid = 1'b0;
            n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_timeout op%0d: got accepted=%0d want 1", i, ok); end
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                if (bus1.rsp_valid) begin ok = 1'b1; break; end
                @(posedge clk); #1;
            end
            n_vec++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_rsp_timeout op%0d: got rsp_valid=%0d want 1", i, ok); end
            n_vec++; if (bus1.rsp_result !== exp_res[i]) begin n_bad++; $display("FAIL b2b_result op%0d: got %0d want %0d", i, bus1.rsp_result, exp_res[i]); end
            n_vec++; if (bus1.rsp_tag !== 4'(i + 8) || bus1.rsp_opcode !== 3'(i)) begin n_bad++; $display("FAIL b2b_tag_op op%0d: got tag=%0d op=%0d want tag=%0d op=%0d", i, bus1.rsp_tag, bus1.rsp_opcode, i + 8, i); end
            @(posedge clk); #1;   // handshake edge
        end
        n_vec++; if (cnt1 !== 16'd6) begin n_bad++; $display("FAIL b2b_op_count: got %0d want 6", cnt1); end
    endtask

    task automatic test_backpressure();
        bus1.rsp_ready = 1'b0;
        bus1.cmd_opcode = 3'd2; bus1.cmd_a = 8'd15; bus1.cmd_b = 8'd5; bus1.cmd_tag = 4'd9;
        bus1.cmd_valid = 1'b1;
        @(posedge clk); #1;   // accept
        bus1.cmd_opcode = 3'd3; bus1.cmd_tag = 4'd10;   // next command waits on the bus
        @(posedge clk); #1;   // capture
        n_vec++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_result !== 8'd5) begin n_bad++; $display("FAIL bp_first_rsp: got valid=%0d result=%0d want valid=1 result=5", bus1.rsp_valid, bus1.rsp_result); end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_vec++; if ({bus1.rsp_valid, bus1.rsp_result, bus1.rsp_opcode, bus1.rsp_tag} !== {1'b1, 8'd5, 3'd2, 4'd9}) begin n_bad++; $display("FAIL bp_hold cycle%0d: got v=%0d r=%0d op=%0d tag=%0d want v=1 r=5 op=2 tag=9", c, bus1.rsp_valid, bus1.rsp_result, bus1.rsp_opcode, bus1.rsp_tag); end
            n_vec++; if (bus1.cmd_ready !== 1'b0 || op1 !== 3'd2) begin n_bad++; $display("FAIL bp_no_accept cycle%0d: got ready=%0d alu_op=%0d want ready=0 alu_op=2", c, bus1.cmd_ready, op1); end
        end
        bus1.rsp_ready = 1'b1;
        @(posedge clk); #1;   // handshake edge M
        n_vec++; if (bus1.rsp_valid !== 1'b0 || bus1.cmd_ready !== 1'b1 || busy1 !== 1'b0) begin n_bad++; $display("FAIL bp_handshake: got valid=%0d ready=%0d busy=%0d want 0/1/0", bus1.rsp_valid, bus1.cmd_ready, busy1); end
        @(posedge clk); #1;   // edge M+1 accepts the waiting command
        bus1.cmd_valid = 1'b0;
        n_vec++; if (busy1 !== 1'b1 || op1 !== 3'd3) begin n_bad++; $display("FAIL bp_next_accept: got busy=%0d alu_op=%0d want busy=1 alu_op=3", busy1, op1); end
        @(posedge clk); #1;
        n_vec++; if (bus1.rsp_result !== 8'd15 || bus1.rsp_tag !== 4'd10) begin n_bad++; $display("FAIL bp_next_rsp: got result=%0d tag=%0d want 15/10", bus1.rsp_result, bus1.rsp_tag); end
        @(posedge clk); #1;
        n_vec++; if (cnt1 !== 16'd8) begin n_bad++; $display("FAIL bp_op_count: got %0d want 8", cnt1); end
    endtask

    task automatic test_settle3();
        bus2.cmd_opcode = 3'd4; bus2.cmd_a = 8'd15; bus2.cmd_b = 8'd5; bus2.cmd_tag = 4'd7;
        bus2.cmd_valid = 1'b1; bus2.rsp_ready = 1'b1;
        @(posedge clk); #1;   // accept edge N
        bus2.cmd_valid = 1'b0;
        bus2.cmd_opcode = 3'd0; bus2.cmd_a = 8'd1;    // bus noise must not reach the ALU
        for (int c = 1; c < 3; c++) begin
            @(posedge clk); #1;
            n_vec++; if (bus2.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL s3_early edge N+%0d: got valid=%0d want 0", c, bus2.rsp_valid); end
            n_vec++; if ({op2, a2, b2} !== {3'd4, 8'd15, 8'd5}) begin n_bad++; $display("FAIL s3_alu_stable edge N+%0d: got %0h want %0h", c, {op2, a2, b2}, {3'd4, 8'd15, 8'd5}); end
        end
        @(posedge clk); #1;   // edge N+3
        n_vec++; if (bus2.rsp_valid !== 1'b1 || bus2.rsp_result !== 8'd10) begin n_bad++; $display("FAIL s3_rsp: got valid=%0d result=%0d want 1/10", bus2.rsp_valid, bus2.rsp_result); end
        n_vec++; if (bus2.rsp_tag !== 4'd7 || bus2.rsp_opcode !== 3'd4) begin n_bad++; $display("FAIL s3_tag_op: got tag=%0d op=%0d want 7/4", bus2.rsp_tag, bus2.rsp_opcode); end
        @(posedge clk); #1;
        n_vec++; if (cnt2 !== 16'd1 || busy2 !== 1'b0) begin n_bad++; $display("FAIL s3_complete: got count=%0d busy=%0d want 1/0", cnt2, busy2); end
    endtask

    task automatic test_reset_abort();
        logic saw_rsp;
        bus1.rsp_ready = 1'b1;
        bus1.cmd_opcode = 3'd0; bus1.cmd_a = 8'd15; bus1.cmd_b = 8'd5; bus1.cmd_tag = 4'd5;
        bus1.cmd_valid = 1'b1;
        @(posedge clk); #1;   // accepted, now in SETTLE
        bus1.cmd_valid = 1'b0;
        n_vec++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL abort_in_settle: got busy=%0d want 1", busy1); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy1 !== 1'b0 || bus1.cmd_ready !== 1'b0 || cnt1 !== 16'd0) begin n_bad++; $display("FAIL abort_async_clear: got busy=%0d ready=%0d count=%0d want 0/0/0", busy1, bus1.cmd_ready, cnt1); end
        n_vec++; if ({op1, a1, b1} !== 19'd0) begin n_bad++; $display("FAIL abort_alu_clear: got %0h want 0", {op1, a1, b1}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_rsp = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus1.rsp_valid) saw_rsp = 1'b1;
        end
        n_vec++; if (saw_rsp !== 1'b0) begin n_bad++; $display("FAIL abort_no_rsp: got saw_rsp=%0d want 0", saw_rsp); end
        n_vec++; if (cnt1 !== 16'd0) begin n_bad++; $display("FAIL abort_op_count: got %0d want 0", cnt1); end
        bus1.cmd_opcode = 3'd1; bus1.cmd_tag = 4'd6; bus1.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus1.cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++; if (bus1.rsp_valid !== 1'b1 || bus1.rsp_result !== 8'd10 || bus1.rsp_tag !== 4'd6) begin n_bad++; $display("FAIL abort_next_rsp: got v=%0d r=%0d tag=%0d want 1/10/6", bus1.rsp_valid, bus1.rsp_result, bus1.rsp_tag); end
        @(posedge clk); #1;
        n_vec++; if (cnt1 !== 16'd1) begin n_bad++; $display("FAIL abort_next_count: got %0d want 1", cnt1); end
    endtask

    initial begin
        rst_n = 1'b1;
        bus1.cmd_valid = 1'b0; bus1.rsp_ready = 1'b0;
        bus1.cmd_opcode = '0; bus1.cmd_a = '0; bus1.cmd_b = '0; bus1.cmd_tag = '0;
        bus2.cmd_valid = 1'b0; bus2.rsp_ready = 1'b0;
        bus2.cmd_opcode = '0; bus2.cmd_a = '0; bus2.cmd_b = '0; bus2.cmd_tag = '0;
        #2 rst_n = 1'b0;

        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_settle3();
        test_reset_abort();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
